// File: rtl/bp_lce_req_rr_mux.sv
// Round-robin merge of per-LCE request streams onto one output channel.
// Each source is buffered in a small FIFO; a stalled grant is locked until it is accepted.
module bp_lce_req_rr_mux #(
    parameter int unsigned num_lce_p      = 2,
    parameter int unsigned header_width_p = 128,
    parameter int unsigned data_width_p   = 512,
    parameter int unsigned fifo_els_p     = 2,
    localparam int unsigned src_width_lp  = (num_lce_p > 1) ? $clog2(num_lce_p) : 1
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic [num_lce_p-1:0]                     chan_en_i,
    input  logic [num_lce_p-1:0][header_width_p-1:0] in_header_i,
    input  logic [num_lce_p-1:0][data_width_p-1:0]   in_data_i,
    input  logic [num_lce_p-1:0]                     in_v_i,
    output logic [num_lce_p-1:0]                     in_ready_and_o,
    output logic [header_width_p-1:0]                out_header_o,
    output logic [data_width_p-1:0]                  out_data_o,
    output logic [src_width_lp-1:0]                  out_src_o,
    output logic                                     out_v_o,
    input  logic                                     out_ready_and_i,
    output logic [15:0]                              sent_cnt_o
);

    localparam int unsigned entry_width_lp = header_width_p + data_width_p;
    localparam int unsigned ptr_width_lp   = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int unsigned cnt_width_lp   = $clog2(fifo_els_p + 1);

    typedef enum logic {
        state_idle,
        state_locked
    } state_e;

    state_e                                   state_q;
    state_e                                   state_d;
    logic [src_width_lp-1:0]                  lock_idx_q;
    logic [src_width_lp-1:0]                  ptr_q;
    logic [src_width_lp-1:0]                  rr_idx;
    logic [src_width_lp-1:0]                  grant_idx;
    logic                                     rr_found;
    logic                                     handshake;
    int unsigned                              cand;
    logic [num_lce_p-1:0]                     eligible;
    logic [num_lce_p-1:0]                     full;
    logic [num_lce_p-1:0]                     empty;
    logic [num_lce_p-1:0][entry_width_lp-1:0] head;
    logic [15:0]                              sent_cnt_q;

    assign handshake  = out_v_o & out_ready_and_i;
    assign sent_cnt_o = sent_cnt_q;

    // Per-source FIFO; readiness depends only on stored occupancy (no dequeue bypass).
    for (genvar k = 0; k < num_lce_p; k++) begin : g_fifo
        logic [entry_width_lp-1:0] mem_q [fifo_els_p];
        logic [ptr_width_lp-1:0]   rd_ptr_q;
        logic [ptr_width_lp-1:0]   wr_ptr_q;
        logic [cnt_width_lp-1:0]   count_q;
        logic                      enq;
        logic                      deq;

        assign enq               = in_v_i[k] & in_ready_and_o[k] & ~reset_i;
        assign deq               = handshake & (grant_idx == src_width_lp'(k));
        assign full[k]           = (count_q == cnt_width_lp'(fifo_els_p));
        assign empty[k]          = (count_q == '0);
        assign eligible[k]       = ~empty[k] & chan_en_i[k];
        assign head[k]           = mem_q[rd_ptr_q];
        assign in_ready_and_o[k] = reset_i | ~full[k];

        always_ff @(posedge clk_i) begin
            if (enq) begin
                mem_q[wr_ptr_q] <= {in_header_i[k], in_data_i[k]};
            end
        end

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (enq) begin
                    wr_ptr_q <= (wr_ptr_q == ptr_width_lp'(fifo_els_p - 1)) ? '0 : wr_ptr_q + 1'b1;
                end
                if (deq) begin
                    rd_ptr_q <= (rd_ptr_q == ptr_width_lp'(fifo_els_p - 1)) ? '0 : rd_ptr_q + 1'b1;
                end
                if (enq & ~deq) begin
                    count_q <= count_q + 1'b1;
                end else if (deq & ~enq) begin
                    count_q <= count_q - 1'b1;
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= state_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: lock on a stalled offer, release on acceptance
    always_comb begin
        state_d = state_q;
        case (state_q)
            state_idle: begin
                if (out_v_o & ~out_ready_and_i) begin
                    state_d = state_locked;
                end
            end
            state_locked: begin
                if (out_ready_and_i) begin
                    state_d = state_idle;
                end
            end
            default: state_d = state_idle;
        endcase
    end

    // Output logic: round-robin pick from the pointer, overridden by a held grant
    always_comb begin
        rr_idx   = '0;
        rr_found = 1'b0;
        cand     = 0;
        for (int unsigned i = 0; i < num_lce_p; i++) begin
            cand = (32'(ptr_q) + i) % num_lce_p;
            if (!rr_found && eligible[src_width_lp'(cand)]) begin
                rr_found = 1'b1;
                rr_idx   = src_width_lp'(cand);
            end
        end
        grant_idx    = (state_q == state_locked) ? lock_idx_q : rr_idx;
        out_v_o      = ~reset_i & ((state_q == state_locked) | rr_found);
        out_header_o = head[grant_idx][entry_width_lp-1 -: header_width_p];
        out_data_o   = head[grant_idx][data_width_p-1:0];
        out_src_o    = grant_idx;
    end

    // Held grant index, priority pointer and saturating transfer counter
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lock_idx_q <= '0;
            ptr_q      <= '0;
            sent_cnt_q <= '0;
        end else begin
            if ((state_q == state_idle) && out_v_o && !out_ready_and_i) begin
                lock_idx_q <= rr_idx;
            end
            if (handshake) begin
                ptr_q <= (32'(grant_idx) == num_lce_p - 1) ? '0 : src_width_lp'(grant_idx + 1'b1);
                if (sent_cnt_q != 16'hFFFF) begin
                    sent_cnt_q <= sent_cnt_q + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bp_lce_req_rr_mux.sv
// Bench for bp_lce_req_rr_mux: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bp_lce_req_rr_mux;

    localparam int N    = 2;
    localparam int HW   = 128;
    localparam int DW   = 512;
    localparam int ELS  = 2;

    typedef struct packed {
        logic [HW-1:0] h;
        logic [DW-1:0] d;
    } ent_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          en;
    logic [N-1:0][HW-1:0]  hdr;
    logic [N-1:0][DW-1:0]  dat;
    logic [N-1:0]          in_v;
    logic [N-1:0]          ready;
    logic [HW-1:0]         out_hdr;
    logic [DW-1:0]         out_dat;
    logic [0:0]            out_src;
    logic                  out_v;
    logic                  rdy;
    logic [15:0]           cnt;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    ent_t mq [N][$];
    int   m_ptr = 0;
    bit   m_locked = 0;
    int   m_lock = 0;
    int   m_cnt = 0;
    int   acc [N];
    int   hs_src [$];
    logic [HW-1:0] hs_hdr [$];

    bp_lce_req_rr_mux #(
        .num_lce_p(N), .header_width_p(HW), .data_width_p(DW), .fifo_els_p(ELS)
    ) dut (
        .clk_i(clk), .reset_i(rst), .chan_en_i(en), .in_header_i(hdr), .in_data_i(dat),
        .in_v_i(in_v), .in_ready_and_o(ready), .out_header_o(out_hdr), .out_data_o(out_dat),
        .out_src_o(out_src), .out_v_o(out_v), .out_ready_and_i(rdy), .sent_cnt_o(cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [639:0] got, input logic [639:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One clock: compare DUT against the model, advance the model, move to next negedge.
    task automatic cycle();
        bit [N-1:0] er;
        bit         v;
        int         g;
        ent_t       f;
        ent_t       e;
        #1;
        v = 0;
        g = 0;
        for (int k = 0; k < N; k++) er[k] = rst || (mq[k].size() < ELS);
        if (!rst) begin
            if (m_locked) begin
                v = 1;
                g = m_lock;
            end else begin
                for (int i = 0; i < N; i++) begin
                    int c = (m_ptr + i) % N;
                    if (!v && mq[c].size() > 0 && en[c]) begin
                        v = 1;
                        g = c;
                    end
                end
            end
        end
        chk("out_v", 640'(out_v), 640'(v));
        chk("in_ready", 640'(ready), 640'(er));
        if (!rst) chk("sent_cnt", 640'(cnt), 640'(m_cnt));
        if (v) begin
            f = mq[g][0];
            chk("out_src", 640'(out_src), 640'(g));
            chk("out_header", 640'(out_hdr), 640'(f.h));
            chk("out_data", 640'(out_dat), 640'(f.d));
        end
        for (int k = 0; k < N; k++) acc[k] = 0;
        if (rst) begin
            for (int k = 0; k < N; k++) mq[k].delete();
            m_ptr = 0;
            m_locked = 0;
            m_lock = 0;
            m_cnt = 0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (in_v[k] && er[k]) begin
                    e.h = hdr[k];
                    e.d = dat[k];
                    mq[k].push_back(e);
                    acc[k] = 1;
                end
            end
            if (v && rdy) begin
                void'(mq[g].pop_front());
                hs_src.push_back(g);
                hs_hdr.push_back(f.h);
                m_ptr = (g + 1) % N;
                if (m_cnt < 65535) m_cnt++;
                m_locked = 0;
            end else if (v) begin
                m_locked = 1;
                m_lock = g;
            end
        end
        @(negedge clk);
    endtask

    task automatic rand_payload();
        for (int k = 0; k < N; k++) begin
            hdr[k] = {$urandom, $urandom, $urandom, $urandom};
            for (int w = 0; w < DW / 32; w++) dat[k][w*32 +: 32] = $urandom;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_v = '0;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int base;
        int pushed [N];
        rst = 1'b1; en = '1; in_v = '0; rdy = 1'b0;
        rand_payload();
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        chk("reset_out_v", 640'(out_v), 640'(0));
        chk("reset_ready", 640'(ready), 640'(2'b11));
        chk("reset_cnt", 640'(cnt), 640'(0));

        // single request on source 1
        en = 2'b11; rdy = 1'b1; in_v = 2'b10; hdr[1] = 128'hA5;
        cycle();
        in_v = '0;
        #1;
        chk("single_v", 640'(out_v), 640'(1));
        chk("single_src", 640'(out_src), 640'(1));
        chk("single_hdr", 640'(out_hdr), 640'(128'hA5));
        cycle();
        #1;
        chk("single_cnt", 640'(cnt), 640'(1));
        chk("single_v_after", 640'(out_v), 640'(0));

        // three requests per source, alternating order
        do_reset();
        en = 2'b11; rdy = 1'b0;
        for (int k = 0; k < N; k++) pushed[k] = 0;
        base = hs_src.size();
        for (int c = 0; c < 12; c++) begin
            for (int k = 0; k < N; k++) begin
                in_v[k] = (pushed[k] < 3);
                hdr[k] = 128'(k * 16 + pushed[k]);
            end
            rdy = (c >= 2);
            cycle();
            for (int k = 0; k < N; k++) pushed[k] += acc[k];
        end
        in_v = '0;
        chk("rr_count", 640'(hs_src.size() - base), 640'(6));
        if (hs_src.size() >= base + 6)
            for (int i = 0; i < 6; i++) chk("rr_order", 640'(hs_src[base + i]), 640'(i % 2));
        #1;
        chk("rr_cnt", 640'(cnt), 640'(6));

        // stall with source 0 granted, source 1 arrives meanwhile
        do_reset();
        en = 2'b11; rdy = 1'b0; in_v = 2'b01; hdr[0] = 128'h100;
        cycle();
        in_v = 2'b10; hdr[1] = 128'h200;
        cycle();
        for (int s = 0; s < 5; s++) begin
            in_v = '0;
            en = (s == 2) ? 2'b10 : 2'b11;
            #1;
            chk("stall_v", 640'(out_v), 640'(1));
            chk("stall_src", 640'(out_src), 640'(0));
            chk("stall_hdr", 640'(out_hdr), 640'(128'h100));
            cycle();
        end
        en = 2'b11; rdy = 1'b1;
        cycle();
        #1;
        chk("after_stall_src", 640'(out_src), 640'(1));
        chk("after_stall_hdr", 640'(out_hdr), 640'(128'h200));
        cycle();

        // source 0 backpressure with depth 2
        do_reset();
        en = 2'b11; rdy = 1'b0; in_v = 2'b01; hdr[0] = 128'h1;
        cycle();
        hdr[0] = 128'h2;
        cycle();
        hdr[0] = 128'h3;
        #1;
        chk("full_ready", 640'(ready[0]), 640'(0));
        cycle();
        rdy = 1'b1;
        #1;
        chk("no_bypass_ready", 640'(ready[0]), 640'(0));
        cycle();
        rdy = 1'b0;
        #1;
        chk("ready_after_hs", 640'(ready[0]), 640'(1));
        base = hs_hdr.size() - 1;
        cycle();
        in_v = '0; rdy = 1'b1;
        for (int c = 0; c < 4; c++) cycle();
        chk("bp_sent", 640'(hs_hdr.size() - base), 640'(3));
        if (hs_hdr.size() >= base + 3)
            for (int i = 0; i < 3; i++) chk("bp_hdr", 640'(hs_hdr[base + i]), 640'(i + 1));

        // channel enable masking
        do_reset();
        en = 2'b10; rdy = 1'b0; in_v = 2'b11; hdr[0] = 128'h10; hdr[1] = 128'h11;
        cycle();
        in_v = '0;
        #1;
        chk("mask_v", 640'(out_v), 640'(1));
        chk("mask_src", 640'(out_src), 640'(1));
        cycle();
        rdy = 1'b1;
        cycle();
        #1;
        chk("mask_idle", 640'(out_v), 640'(0));
        cycle();
        en = 2'b11;
        #1;
        chk("unmask_src", 640'(out_src), 640'(0));
        chk("unmask_hdr", 640'(out_hdr), 640'(128'h10));
        cycle();

        // reset while locked with four entries buffered
        do_reset();
        en = 2'b11; rdy = 1'b0; in_v = 2'b11;
        cycle();
        cycle();
        in_v = '0;
        cycle();
        rst = 1'b1;
        #1;
        chk("rst_lock_v", 640'(out_v), 640'(0));
        cycle();
        rst = 1'b0;
        #1;
        chk("post_rst_v", 640'(out_v), 640'(0));
        chk("post_rst_cnt", 640'(cnt), 640'(0));
        rdy = 1'b1;
        for (int c = 0; c < 6; c++) cycle();
        chk("no_stale_cnt", 640'(cnt), 640'(0));

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            in_v = 2'($urandom);
            for (int k = 0; k < N; k++) en[k] = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            rand_payload();
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bp_lce_req_rr_mux.md
BP_LCE_REQ_RR_MUX -- requirements
Module: bp_lce_req_rr_mux

Interface
REQ-001 The block SHALL use parameter num_lce_p, default 2, giving the number of LCE request sources (1..8).
REQ-002 The block SHALL use parameter header_width_p, default 128, giving the LCE request header width in bits.
REQ-003 The block SHALL use parameter data_width_p, default 512, giving the request data (cache block) width in bits.
REQ-004 The block SHALL use parameter fifo_els_p, default 2, giving the per-source buffer depth (>=2).
REQ-005 The block SHALL use localparam src_width_lp = max(1, clog2(num_lce_p)).
REQ-006 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port chan_en_i, input, num_lce_p bits: per-source grant enable.
REQ-009 The block SHALL have port in_header_i, input, num_lce_p x header_width_p bits: per-source request headers.
REQ-010 The block SHALL have port in_data_i, input, num_lce_p x data_width_p bits: per-source request data.
REQ-011 The block SHALL have port in_v_i, input, num_lce_p bits: per-source valid.
REQ-012 The block SHALL have port in_ready_and_o, output, num_lce_p bits: per-source ready (ready-and handshake).
REQ-013 The block SHALL have port out_header_o, output, header_width_p bits: merged header.
REQ-014 The block SHALL have port out_data_o, output, data_width_p bits: merged data.
REQ-015 The block SHALL have port out_src_o, output, src_width_lp bits: index of the source of the current output.
REQ-016 The block SHALL have port out_v_o, output, 1 bit: output valid.
REQ-017 The block SHALL have port out_ready_and_i, input, 1 bit: downstream ready.
REQ-018 The block SHALL have port sent_cnt_o, output, 16 bits: count of accepted output transfers.

Function
REQ-019 Each source SHALL have a FIFO of fifo_els_p entries holding {header, data}; an entry is enqueued when in_v_i[k] & in_ready_and_o[k].
REQ-020 in_ready_and_o[k] SHALL be 1 iff FIFO k is not full, with no bypass: a full FIFO stays not-ready even in a cycle where it dequeues.
REQ-021 Enqueue-to-output latency SHALL be 1 cycle minimum: an entry enqueued at edge t is eligible to appear at out_v_o from cycle t+1; there is no combinational input-to-output path.
REQ-022 Source k SHALL be eligible iff FIFO k is non-empty and chan_en_i[k]=1.
REQ-023 Arbitration SHALL be round-robin: starting from priority pointer p, grant the first eligible index in order p, p+1, ..., wrapping modulo num_lce_p.
REQ-024 The pointer SHALL reset to 0 and, on each output handshake (out_v_o & out_ready_and_i), become (granted index + 1) mod num_lce_p; otherwise it holds.
REQ-025 The block SHALL be a two-state FSM: IDLE (no grant held) and LOCKED (grant held).
REQ-026 IDLE -> LOCKED SHALL occur when out_v_o=1 and out_ready_and_i=0; the granted index is registered.
REQ-027 LOCKED -> IDLE SHALL occur on the handshake.
REQ-028 In LOCKED, out_header_o, out_data_o and out_src_o SHALL remain stable and out_v_o SHALL remain 1 regardless of chan_en_i or the arrival of other requests.
REQ-029 out_v_o SHALL be 1 iff the FSM is in LOCKED or any source is eligible; the output is driven from the head of the granted FIFO, which dequeues exactly on the handshake.
REQ-030 Simultaneous enqueue and dequeue on the same non-full FIFO SHALL both take effect, leaving occupancy unchanged.
REQ-031 sent_cnt_o SHALL increment by 1 per handshake and saturate at 0xFFFF.
REQ-032 When num_lce_p=1, out_src_o SHALL be constant 0 and the arbiter SHALL degenerate to a pass-through of FIFO 0.
REQ-033 When out_v_o=0, out_header_o, out_data_o and out_src_o are don't-care.

Reset
REQ-034 While reset_i=1 at an edge, all FIFOs SHALL empty, the pointer SHALL be 0, the FSM SHALL be IDLE and sent_cnt_o SHALL be 0.
REQ-035 During and in the cycle after reset, out_v_o=0 and in_ready_and_o=all-ones.
REQ-036 Reset asserted mid-operation, including in LOCKED, SHALL discard buffered and held requests without any handshake.

Verification
REQ-037 Scenario: num_lce_p=2, single request on source 1 (header 0xA5), out_ready_and_i=1 -> out_v_o rises the next cycle with out_src_o=1 and header 0xA5; sent_cnt_o=1.
REQ-038 Scenario: both sources hold 3 requests each and out_ready_and_i is held at 1 -> output order is sources 0,1,0,1,0,1; sent_cnt_o=6.
REQ-039 Scenario: out_ready_and_i=0 for 5 cycles with source 0 granted, and source 1 becomes valid meanwhile -> output held stable on source 0 for the full stall, then source 1 is sent next.
REQ-040 Scenario: fifo_els_p=2, source 0 is pushed 3 times while the output is stalled -> in_ready_and_o[0]=0 after 2 enqueues; the third is accepted only after the first handshake.
REQ-041 Scenario: chan_en_i=2'b10 with both FIFOs non-empty -> only source 1 is granted; source 0 is sent after chan_en_i[0] returns to 1.
REQ-042 Scenario: reset asserted while in LOCKED with 4 entries buffered -> the next cycle shows out_v_o=0 and sent_cnt_o=0, and no stale entries emerge afterwards.
